spi_slave_frontend: RTL and testbench
=====================================

SPI_SLAVE_FRONTEND -- requirements
Module: spi_slave_frontend

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, maximum word length in bits (legal range 2..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for sck/cs/mosi (legal range 2..4).
REQ-003 SHALL have parameter CNT_W, default $clog2(DATA_WIDTH+1), width of the word_len and bit_cnt ports.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cpol, cpha  in  1 each  SPI mode; sampled only while idle, frozen while busy.
REQ-007 word_len  in  CNT_W  bits per word; latched at spi_start; 0 or >DATA_WIDTH treated as DATA_WIDTH; 1 treated as 2.
REQ-008 sck, cs, mosi  in  1 each  asynchronous pins; cs active-low.
REQ-009 tx_data  in  DATA_WIDTH  next transmit word, right-aligned.
REQ-010 miso  out  1  transmit bit (MSB of active word first); miso_oe  out  1  high while busy.
REQ-011 tx_load_ack  out  1  one-cycle pulse when tx_data is captured.
REQ-012 rx_data  out  DATA_WIDTH  last complete word, right-aligned, upper unused bits zero; rx_valid  out  1  one-cycle pulse.
REQ-013 spi_start, spi_finish, frame_abort  out  1 each  one-cycle event pulses.
REQ-014 busy  out  1  state==ACTIVE; bit_cnt  out  CNT_W  bits received in the current word.

Function
REQ-015 sck, cs, mosi SHALL each pass through SYNC_STAGES flops; sck_s/cs_s/mosi_s denote the last stage.
REQ-016 sck_h = sck_s XOR cpol_l; leading edge = sck_h 0->1, trailing edge = sck_h 1->0, detected against a registered sck_h_last.
REQ-017 sample_stb = leading edge if cpha_l=0, else trailing edge; shift_stb = the other edge; both are gated by busy.
REQ-018 Pin-to-event latency: an edge on sck or cs first sampled at clk edge k SHALL produce its registered effect at clk edge k+SYNC_STAGES+1.
REQ-019 FSM states: IDLE, ACTIVE. IDLE->ACTIVE on cs_s 1->0. ACTIVE->IDLE on cs_s 0->1. No other transitions.
REQ-020 On IDLE->ACTIVE: pulse spi_start; latch cpol/cpha/word_len; load tx_shift from tx_data; pulse tx_load_ack; bit_cnt=0; set first_shift.
REQ-021 miso SHALL equal tx_shift[word_len_l-1] at all times while busy, and 0 while idle.
REQ-022 On shift_stb: if first_shift and cpha_l=1, clear first_shift only; otherwise shift tx_shift left by one.
REQ-023 On sample_stb: rx_shift <= {rx_shift, mosi_s}; bit_cnt++.
REQ-024 When sample_stb occurs with bit_cnt==word_len_l-1: rx_data <= completed word (upper bits zeroed); rx_valid=1 next cycle; bit_cnt=0; reload tx_shift from tx_data; pulse tx_load_ack; set first_shift.
REQ-025 On ACTIVE->IDLE: pulse spi_finish; pulse frame_abort if bit_cnt!=0; discard partial word; bit_cnt=0.
REQ-026 If cs_s rises in the same cycle as a sample_stb, the finish takes priority: no rx_valid, no bit_cnt increment; frame_abort follows the pre-edge bit_cnt.
REQ-027 sck edges coincident with the cs falling edge, or occurring while idle, SHALL be ignored. sck_h_last SHALL still track sck_h.
REQ-028 cpol changes while idle SHALL NOT generate strobes.
REQ-029 Back-to-back words within one frame SHALL be supported with no gap, up to 1 sck edge per 4 clk cycles.

Reset
REQ-030 While rst=1 at a clk edge, the following SHALL be set. Synchronizer flops: sck 0, cs 1, mosi 0. State: IDLE. Outputs and shifters: all 0. miso_oe: 0. Mode latches: 0. word_len_l: DATA_WIDTH.
REQ-031 Reset asserted mid-frame SHALL abort silently: no spi_finish, no frame_abort, no rx_valid. After release, cs held low SHALL NOT produce spi_start until cs returns high.

Verification
REQ-032 Mode 0, word_len=8, master sends 0xA5 while tx_data=0x3C -> one rx_valid with rx_data=0x A5; master samples 0x3C; bit_cnt returns to 0.
REQ-033 Mode 3, word_len=8, two words 0x81 and 0x7E in one frame -> two rx_valid pulses with the matching data; tx_load_ack pulses 2x plus 1 at start; spi_finish at the end; no frame_abort.
REQ-034 Mode 1, word_len=5, word 0x15 -> rx_data=0x15 (bits 7:5 zero); miso shows tx_data[4:0] MSB first, shifted out on leading edges.
REQ-035 cs rises after 3 bits, then a new frame of 8 bits 0xF0 -> frame_abort pulse; no rx_valid for the partial word; second frame rx_data=0xF0.
REQ-036 rst asserted after 4 bits with cs held low -> all outputs 0 the following cycle; no spi_start until cs goes high then low.
REQ-037 sck toggled with cs high, including a cpol change -> no rx_valid, bit_cnt stays 0, miso_oe stays 0.

Source files
------------

// File: rtl/spi_slave_frontend.sv
// spi_slave_frontend: SPI slave with pin synchronizers, mode/length latching, shifters and framing events.
module spi_slave_frontend #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cpol,
  input  logic                  i_cpha,
  input  logic [CNT_W-1:0]      i_word_len,
  input  logic                  i_sck,
  input  logic                  i_cs,
  input  logic                  i_mosi,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  output logic                  o_miso,
  output logic                  o_miso_oe,
  output logic                  o_tx_load_ack,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_spi_start,
  output logic                  o_spi_finish,
  output logic                  o_frame_abort,
  output logic                  o_busy,
  output logic [CNT_W-1:0]      o_bit_cnt
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam logic [CNT_W-1:0] DW_C = CNT_W'(DATA_WIDTH);
  state_t                r_state;
  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
  logic [SYNC_STAGES:0]  r_vld;
  logic                  r_sck_h, r_sck_h_last, r_cs_d, r_cs_last, r_mosi_d, r_armed;
  logic                  r_cpol_l, r_cpha_l, r_first_shift;
  logic [CNT_W-1:0]      r_word_len_l, r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_tx_shift, r_rx_shift, r_rx_data;
  logic                  r_tx_load_ack, r_rx_valid, r_spi_start, r_spi_finish, r_frame_abort;
  logic                  w_busy, w_lead, w_trail, w_sample, w_shift, w_cs_fall, w_cs_rise, w_last;
  logic [CNT_W-1:0]      w_len, w_msb;
  logic [DATA_WIDTH-1:0] w_rx_next, w_mask, w_tx_sh;
  assign w_busy    = r_state == ACTIVE;
  assign w_lead    = r_sck_h & ~r_sck_h_last;
  assign w_trail   = ~r_sck_h & r_sck_h_last;
  assign w_sample  = w_busy & (r_cpha_l ? w_trail : w_lead);
  assign w_shift   = w_busy & (r_cpha_l ? w_lead : w_trail);
  assign w_cs_fall = r_cs_last & ~r_cs_d;
  assign w_cs_rise = ~r_cs_last & r_cs_d;
  assign w_len     = (i_word_len == '0 || i_word_len > DW_C) ? DW_C :
                     (i_word_len == CNT_W'(1) ? CNT_W'(2) : i_word_len);
  assign w_msb     = r_word_len_l - CNT_W'(1);
  assign w_last    = r_bit_cnt == w_msb;
  assign w_rx_next = {r_rx_shift[DATA_WIDTH-2:0], r_mosi_d};
  assign w_mask    = ~({DATA_WIDTH{1'b1}} << r_word_len_l);
  assign w_tx_sh   = r_tx_shift >> w_msb;
  assign o_miso        = w_busy & w_tx_sh[0];
  assign o_miso_oe     = w_busy;
  assign o_busy        = w_busy;
  assign o_bit_cnt     = r_bit_cnt;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_tx_load_ack = r_tx_load_ack;
  assign o_spi_start   = r_spi_start;
  assign o_spi_finish  = r_spi_finish;
  assign o_frame_abort = r_frame_abort;
  // r_vld tracks when r_cs_d holds a real pin sample after reset; r_armed waits for cs high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_sck_sync    <= '0;
      r_cs_sync     <= '1;
      r_mosi_sync   <= '0;
      r_vld         <= '0;
      r_sck_h       <= 1'b0;
      r_sck_h_last  <= 1'b0;
      r_cs_d        <= 1'b1;
      r_cs_last     <= 1'b1;
      r_mosi_d      <= 1'b0;
      r_armed       <= 1'b0;
      r_cpol_l      <= 1'b0;
      r_cpha_l      <= 1'b0;
      r_first_shift <= 1'b0;
      r_word_len_l  <= DW_C;
      r_bit_cnt     <= '0;
      r_tx_shift    <= '0;
      r_rx_shift    <= '0;
      r_rx_data     <= '0;
      r_tx_load_ack <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_spi_start   <= 1'b0;
      r_spi_finish  <= 1'b0;
      r_frame_abort <= 1'b0;
    end else begin
      r_sck_sync    <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
      r_cs_sync     <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
      r_mosi_sync   <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_vld         <= {r_vld[SYNC_STAGES-1:0], 1'b1};
      r_sck_h       <= r_sck_sync[SYNC_STAGES-1] ^ (w_busy ? r_cpol_l : i_cpol);
      r_sck_h_last  <= r_sck_h;
      r_cs_d        <= r_cs_sync[SYNC_STAGES-1];
      r_cs_last     <= r_cs_d;
      r_mosi_d      <= r_mosi_sync[SYNC_STAGES-1];
      r_armed       <= r_armed | (r_vld[SYNC_STAGES] & r_cs_d);
      r_tx_load_ack <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_spi_start   <= 1'b0;
      r_spi_finish  <= 1'b0;
      r_frame_abort <= 1'b0;
      if (!w_busy) begin
        if (r_armed && w_cs_fall) begin
          r_state       <= ACTIVE;
          r_spi_start   <= 1'b1;
          r_cpol_l      <= i_cpol;
          r_cpha_l      <= i_cpha;
          r_word_len_l  <= w_len;
          r_tx_shift    <= i_tx_data;
          r_tx_load_ack <= 1'b1;
          r_bit_cnt     <= '0;
          r_first_shift <= 1'b1;
        end
      end else if (w_cs_rise) begin
        r_state       <= IDLE;
        r_spi_finish  <= 1'b1;
        r_frame_abort <= r_bit_cnt != '0;
        r_bit_cnt     <= '0;
      end else begin
        if (w_shift) begin
          r_first_shift <= 1'b0;
          r_tx_shift    <= (r_first_shift && r_cpha_l) ? r_tx_shift : r_tx_shift << 1;
        end
        if (w_sample) begin
          r_rx_shift <= w_rx_next;
          r_bit_cnt  <= w_last ? '0 : r_bit_cnt + CNT_W'(1);
          if (w_last) begin
            r_rx_data     <= w_rx_next & w_mask;
            r_rx_valid    <= 1'b1;
            r_tx_shift    <= i_tx_data;
            r_tx_load_ack <= 1'b1;
            r_first_shift <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_frontend.sv
// tb_spi_slave_frontend: vector table, corner sequences and randomized frames against a frame-level model.
module tb_spi_slave_frontend;
  localparam int DW = 8;
  localparam int CW = $clog2(DW + 1);
  localparam int H  = 6;
  logic clk = 1'b0;
  logic rst, cpol, cpha, sck, cs, mosi;
  logic [CW-1:0] word_len;
  logic [DW-1:0] tx_data, rx_data;
  logic [CW-1:0] bit_cnt;
  logic miso, miso_oe, tx_load_ack, rx_valid, spi_start, spi_finish, frame_abort, busy;
  spi_slave_frontend #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .i_cpol(cpol), .i_cpha(cpha), .i_word_len(word_len),
    .i_sck(sck), .i_cs(cs), .i_mosi(mosi), .i_tx_data(tx_data),
    .o_miso(miso), .o_miso_oe(miso_oe), .o_tx_load_ack(tx_load_ack),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid), .o_spi_start(spi_start),
    .o_spi_finish(spi_finish), .o_frame_abort(frame_abort), .o_busy(busy), .o_bit_cnt(bit_cnt)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int n_start = 0, n_finish = 0, n_abort = 0, n_ack = 0, n_rxv = 0;
  logic [DW-1:0] rxq[$];
  bit mq[$];
  always @(negedge clk) begin
    if (spi_start) n_start++;
    if (spi_finish) n_finish++;
    if (frame_abort) n_abort++;
    if (tx_load_ack) n_ack++;
    if (rx_valid) begin
      n_rxv++;
      rxq.push_back(rx_data);
    end
  end
  typedef struct {
    bit pol, pha;
    int wl, nbits;
    logic [31:0] stream;
    logic [7:0] tx;
    int n;
    logic [7:0] e0, e1;
    bit ab;
    logic [7:0] em;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic int eff(input int wl);
    return (wl == 0 || wl > DW) ? DW : (wl == 1 ? 2 : wl);
  endfunction
  task automatic xfer(input bit pol, input bit pha, input int nbits, input logic [31:0] stream);
    cs = 1'b1;
    cpol = pol;
    cpha = pha;
    sck = pol;
    tick(H);
    cs = 1'b0;
    tick(H);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!pha) begin
        mosi = stream[i];
        tick(H);
        mq.push_back(miso);
        sck = ~sck;
        tick(H);
        sck = ~sck;
      end else begin
        sck = ~sck;
        mosi = stream[i];
        tick(H);
        mq.push_back(miso);
        sck = ~sck;
        tick(H);
      end
    end
    tick(H);
    cs = 1'b1;
    tick(2 * H);
  endtask
  task automatic run_frame(input bit pol, input bit pha, input int wl, input int nbits,
                           input logic [31:0] stream, input logic [DW-1:0] tx, input int exp_n,
                           input logic [DW-1:0] e0, input logic [DW-1:0] e1, input bit exp_ab,
                           input logic [DW-1:0] em);
    int s_st, s_fi, s_ab, s_ack, s_rx, rd0, len;
    logic [31:0] m;
    s_st = n_start; s_fi = n_finish; s_ab = n_abort; s_ack = n_ack; s_rx = n_rxv;
    rd0 = rxq.size();
    mq.delete();
    word_len = CW'(wl);
    tx_data = tx;
    xfer(pol, pha, nbits, stream);
    len = eff(wl);
    chk("rx_count", n_rxv - s_rx, exp_n);
    if (exp_n > 0) chk("rx_word0", rxq[rd0], e0);
    if (exp_n > 1) chk("rx_word1", rxq[rd0 + 1], e1);
    chk("spi_start", n_start - s_st, 1);
    chk("spi_finish", n_finish - s_fi, 1);
    chk("frame_abort", n_abort - s_ab, exp_ab);
    chk("tx_load_ack", n_ack - s_ack, 1 + exp_n);
    if (exp_n > 0) begin
      m = 0;
      for (int i = 0; i < len; i++) m = (m << 1) | 32'(mq[i]);
      chk("miso_word", m, em);
    end
    chk("bit_cnt_end", bit_cnt, 0);
    chk("busy_end", busy, 0);
  endtask
  initial begin
    int s_st, s_fi, s_ab, s_rx;
    tbl[0] = '{1'b0, 1'b0, 8, 8, 32'hA5, 8'h3C, 1, 8'hA5, 8'h00, 1'b0, 8'h3C};
    tbl[1] = '{1'b1, 1'b1, 8, 16, 32'h817E, 8'h3C, 2, 8'h81, 8'h7E, 1'b0, 8'h3C};
    tbl[2] = '{1'b0, 1'b1, 5, 5, 32'h15, 8'hEB, 1, 8'h15, 8'h00, 1'b0, 8'h0B};
    tbl[3] = '{1'b0, 1'b0, 8, 3, 32'h5, 8'h3C, 0, 8'h00, 8'h00, 1'b1, 8'h00};
    tbl[4] = '{1'b0, 1'b0, 8, 8, 32'hF0, 8'h3C, 1, 8'hF0, 8'h00, 1'b0, 8'h3C};
    tbl[5] = '{1'b1, 1'b0, 0, 8, 32'h5A, 8'hC3, 1, 8'h5A, 8'h00, 1'b0, 8'hC3};
    tbl[6] = '{1'b0, 1'b1, 1, 4, 32'hD, 8'h02, 2, 8'h03, 8'h01, 1'b0, 8'h02};
    tbl[7] = '{1'b1, 1'b0, 12, 10, 32'h333, 8'h96, 1, 8'hCC, 8'h00, 1'b1, 8'h96};
    rst = 1'b1; cpol = 1'b0; cpha = 1'b0; sck = 1'b0; cs = 1'b1; mosi = 1'b0;
    word_len = CW'(8); tx_data = 8'h3C;
    tick(3);
    @(negedge clk);
    chk("reset_outputs", {busy, miso_oe, miso, rx_valid, spi_start, spi_finish, frame_abort,
                          tx_load_ack, bit_cnt, rx_data}, 0);
    rst = 1'b0;
    tick(2 * H);
    // cs fall timing: first sampled at the next edge, start visible three edges later
    cs = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("start_latency_early", spi_start, 0);
    @(posedge clk);
    @(negedge clk);
    chk("start_latency", {spi_start, busy, miso_oe}, 3'b111);
    for (int i = 0; i < 4; i++) begin
      tick(H);
      mosi = i[0];
      tick(H);
      sck = 1'b1;
      tick(H);
      sck = 1'b0;
    end
    tick(H);
    chk("bit_cnt_mid", bit_cnt, 4);
    s_st = n_start; s_fi = n_finish; s_ab = n_abort; s_rx = n_rxv;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_midframe", {busy, miso_oe, miso, rx_valid, spi_start, spi_finish, frame_abort,
                           tx_load_ack, bit_cnt, rx_data}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sck = ~sck;
      tick(H);
    end
    chk("no_start_cs_low", n_start - s_st, 0);
    chk("silent_abort", (n_finish - s_fi) + (n_abort - s_ab) + (n_rxv - s_rx), 0);
    chk("idle_after_reset", busy, 0);
    cs = 1'b1;
    sck = 1'b0;
    tick(2 * H);
    for (int v = 0; v < 8; v++)
      run_frame(tbl[v].pol, tbl[v].pha, tbl[v].wl, tbl[v].nbits, tbl[v].stream, tbl[v].tx,
                tbl[v].n, tbl[v].e0, tbl[v].e1, tbl[v].ab, tbl[v].em);
    // cs rising together with the 8th sampling edge: the finish wins
    s_fi = n_finish; s_ab = n_abort; s_rx = n_rxv;
    cpol = 1'b0; cpha = 1'b0; sck = 1'b0; word_len = CW'(8);
    tick(H);
    cs = 1'b0;
    tick(H);
    for (int i = 0; i < 7; i++) begin
      mosi = 1'b1;
      tick(H);
      sck = 1'b1;
      tick(H);
      sck = 1'b0;
    end
    tick(H);
    sck = 1'b1;
    cs = 1'b1;
    tick(2 * H);
    sck = 1'b0;
    tick(H);
    chk("coinc_no_rx", n_rxv - s_rx, 0);
    chk("coinc_finish", n_finish - s_fi, 1);
    chk("coinc_abort", n_abort - s_ab, 1);
    chk("coinc_bit_cnt", bit_cnt, 0);
    s_st = n_start; s_rx = n_rxv;
    for (int i = 0; i < 8; i++) begin
      sck = ~sck;
      if (i == 3) cpol = ~cpol;
      tick(3);
      chk("idle_sck", {miso_oe, bit_cnt}, 0);
    end
    chk("idle_no_rx", n_rxv - s_rx, 0);
    chk("idle_no_start", n_start - s_st, 0);
    for (int r = 0; r < 20; r++) begin
      bit pol, pha;
      int wl, nb, len, n;
      logic [31:0] st, mask;
      logic [DW-1:0] tx;
      pol = 1'($urandom);
      pha = 1'($urandom);
      wl = $urandom_range(0, 10);
      nb = $urandom_range(1, 20);
      st = $urandom;
      tx = DW'($urandom);
      len = eff(wl);
      n = nb / len;
      mask = (32'd1 << len) - 1;
      run_frame(pol, pha, wl, nb, st, tx, n,
                DW'((st >> (nb - len)) & mask),
                (n > 1) ? DW'((st >> (nb - 2 * len)) & mask) : '0,
                (nb % len) != 0, DW'(32'(tx) & mask));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
